// File: rtl/vga_capture_rx.sv
// Recovers pixel/line position from VGA sync edges, locks to the nominal frame timing and
// emits one registered frame-buffer write (1 bit per colour) per active pixel, 1 clk after its sample.
module vga_capture_rx #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_START  = 144,
  parameter int V_START  = 35,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsynch,
  input  logic        vsynch,
  input  logic [7:0]  vga_red,
  input  logic [7:0]  vga_green,
  input  logic [7:0]  vga_blue,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [2:0]  wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic        timing_err
);

  localparam logic [11:0] HT_L      = 12'(H_TOTAL);
  localparam logic [10:0] VT_L      = 11'(V_TOTAL);
  localparam logic [10:0] HS_L      = 11'(H_START);
  localparam logic [10:0] HE_L      = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  VS_L      = 10'(V_START);
  localparam logic [9:0]  VE_L      = 10'(V_START + V_ACTIVE);
  localparam logic [18:0] LAST_ADDR = 19'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state;
  logic        prev_hs, prev_vs, vs_pend, bad_flag, skip_line;
  logic [10:0] p;
  logic [9:0]  q;
  logic [18:0] addr_cnt;

  logic        hs_fall, vs_fall, boundary;
  logic [10:0] p_nxt;
  logic [9:0]  q_nxt;
  logic [11:0] line_len;
  logic [10:0] frame_len;
  logic        line_bad, line_chk, frame_bad, active, err, wr_go;
  logic [18:0] addr_cur;
  logic        unused;

  assign unused = ^{vga_red[6:0], vga_green[6:0], vga_blue[6:0]};

  always_comb begin
    hs_fall   = prev_hs & ~hsynch;
    vs_fall   = prev_vs & ~vsynch;
    boundary  = hs_fall & (vs_pend | vs_fall);
    line_len  = {1'b0, p} + 12'd1;
    frame_len = {1'b0, q} + 11'd1;
    p_nxt     = hs_fall ? 11'd0 : ((p == 11'h7FF) ? p : p + 11'd1);
    q_nxt     = q;
    if (boundary)
      q_nxt = 10'd0;
    else if (hs_fall && q != 10'h3FF)
      q_nxt = q + 10'd1;
    line_bad  = hs_fall && (line_len != HT_L);
    // the first line after leaving SEARCH started at an unknown point
    line_chk  = line_bad && !skip_line;
    frame_bad = boundary && (frame_len != VT_L);
    active    = (p_nxt >= HS_L) && (p_nxt < HE_L) && (q_nxt >= VS_L) && (q_nxt < VE_L);
    err       = (state == LOCKED) && (line_bad || frame_bad);
    wr_go     = (state == LOCKED) && !err && active;
    addr_cur  = boundary ? 19'd0 : addr_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      prev_hs    <= 1'b1;
      prev_vs    <= 1'b1;
      vs_pend    <= 1'b0;
      bad_flag   <= 1'b0;
      skip_line  <= 1'b0;
      p          <= '0;
      q          <= '0;
      addr_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      timing_err <= 1'b0;
      if (pix_en) begin
        prev_hs <= hsynch;
        prev_vs <= vsynch;
        p       <= p_nxt;
        q       <= q_nxt;
        vs_pend <= (vs_pend | vs_fall) & ~boundary;
        if (boundary)
          addr_cnt <= '0;
        if (wr_go) begin
          wr_en      <= 1'b1;
          wr_addr    <= addr_cur;
          wr_data    <= {vga_red[7], vga_green[7], vga_blue[7]};
          frame_done <= (addr_cur == LAST_ADDR);
          if (addr_cur != LAST_ADDR)
            addr_cnt <= addr_cur + 19'd1;
        end
        case (state)
          SEARCH: begin
            if (boundary) begin
              state     <= MEASURE;
              bad_flag  <= 1'b0;
              skip_line <= 1'b1;
            end
          end
          MEASURE: begin
            if (hs_fall) begin
              skip_line <= 1'b0;
              if (boundary) begin
                if (!bad_flag && !line_chk && !frame_bad) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
                bad_flag <= 1'b0;
              end else if (line_chk) begin
                bad_flag <= 1'b1;
              end
            end
          end
          LOCKED: begin
            // a mid-frame line error poisons the rest of that frame's measurement
            if (err) begin
              state      <= MEASURE;
              locked     <= 1'b0;
              timing_err <= 1'b1;
              bad_flag   <= ~boundary;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_capture_rx.sv
// Bench for vga_capture_rx on a scaled raster: driver feeds a generated sync stream and pushes
// expected writes/lock changes/errors into queues; a monitor pops and compares them as the DUT emits.
module tb_vga_capture_rx;

  localparam int HT = 40, VT = 20, HS = 8, VS = 3, HA = 24, VA = 12, HSW = 4;
  localparam int ST_SEARCH = 0, ST_MEASURE = 1, ST_LOCKED = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0, hsynch = 1'b1, vsynch = 1'b1;
  logic [7:0]  vga_red = '0, vga_green = '0, vga_blue = '0;
  logic        wr_en, locked, frame_done, timing_err;
  logic [18:0] wr_addr;
  logic [2:0]  wr_data;

  vga_capture_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsynch(hsynch), .vsynch(vsynch),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .locked(locked), .frame_done(frame_done), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int stamp; int addr; int data; bit fd; } wr_t;
  typedef struct { int stamp; bit val; } lk_t;
  wr_t wq[$];
  lk_t lq[$];
  int  eq[$];

  int checks = 0, errors = 0;
  int n_exp = 0, n_seen = 0;

  // reference model state, expressed per raster event
  int m_st = ST_SEARCH;
  bit m_bad = 0, m_ign = 0, m_lk = 0;
  int cur_len = 0, lines_cnt = 0;
  bit rand_gaps = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual 1 expected 0 (cycle %0d)", name, cyc);
  endtask

  // line end (hsynch fall): line length, whether it is a frame boundary, frame length
  task automatic model_line_end(input int len, input bit bnd, input int flen, output bit err);
    bit lb;
    lb  = (len != HT);
    err = 0;
    if (m_st == ST_SEARCH) begin
      if (bnd) begin m_st = ST_MEASURE; m_bad = 0; m_ign = 1; end
    end else if (m_st == ST_MEASURE) begin
      if (m_ign) lb = 0;
      m_ign = 0;
      if (bnd) begin
        if (!m_bad && !lb && flen == VT) m_st = ST_LOCKED;
        m_bad = 0;
      end else if (lb) m_bad = 1;
    end else if (lb || (bnd && flen != VT)) begin
      err  = 1;
      m_st = ST_MEASURE;
      m_bad = !bnd;
    end
  endtask

  task automatic sample(input int line, input int pix);
    int gap, stamp;
    bit err, bnd;
    logic [7:0] r, g, b;
    wr_t w;
    gap = rand_gaps ? int'($urandom_range(5, 0)) : 1;
    repeat (gap) begin @(negedge clk); pix_en = 1'b0; end
    @(negedge clk);
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    if (line == VS + 1 && pix == HS) begin r = 8'h80; g = 8'h7F; b = 8'hFF; end
    pix_en = 1'b1;
    hsynch = (pix >= HSW);
    vsynch = (line >= 2);
    vga_red = r; vga_green = g; vga_blue = b;
    stamp = cyc + 1;
    if (pix == 0) begin
      bnd = (line == 0);
      model_line_end(cur_len, bnd, lines_cnt, err);
      if (err) eq.push_back(stamp);
      cur_len = 0;
      if (bnd) lines_cnt = 0;
      lines_cnt++;
    end
    cur_len++;
    if ((m_st == ST_LOCKED) != m_lk) begin
      m_lk = !m_lk;
      lq.push_back('{stamp, m_lk});
    end
    if (m_st == ST_LOCKED && line >= VS && line < VS + VA && pix >= HS && pix < HS + HA) begin
      w.stamp = stamp;
      w.addr  = (line - VS) * HA + (pix - HS);
      w.data  = int'({r[7], g[7], b[7]});
      w.fd    = (w.addr == HA * VA - 1);
      wq.push_back(w);
      n_exp++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    pix_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_timing_err", int'(timing_err), 0);
    if (m_lk) begin lq.push_back('{cyc + 1, 1'b0}); m_lk = 0; end
    m_st = ST_SEARCH; m_bad = 0; m_ign = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame(input int nlines, input int short_line, input int rst_line);
    for (int l = 0; l < nlines; l++)
      for (int x = 0; x < ((l == short_line) ? HT - 1 : HT); x++) begin
        if (l == rst_line && x == 20) apply_reset();
        sample(l, x);
      end
  endtask

  // monitor
  initial begin
    logic pl;
    wr_t  e;
    lk_t  k;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        n_seen++;
        if (wq.size() == 0) unexpected("extra_write");
        else begin
          e = wq.pop_front();
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("wr_data", int'(wr_data), e.data);
          chk("wr_latency_cycle", cyc, e.stamp);
          chk("frame_done", int'(frame_done), int'(e.fd));
          if (e.addr == HA) chk("pixel_data_row36", int'(wr_data), 5);
        end
      end else if (frame_done) unexpected("frame_done_without_write");
      if (timing_err) begin
        if (eq.size() == 0) unexpected("extra_timing_err");
        else chk("timing_err_cycle", cyc, eq.pop_front());
      end
      if (locked !== pl) begin
        if (lq.size() == 0) unexpected("extra_locked_change");
        else begin
          k = lq.pop_front();
          chk("locked_value", int'(locked), int'(k.val));
          chk("locked_cycle", cyc, k.stamp);
        end
        pl = locked;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_wr_addr", int'(wr_addr), 0);
    chk("reset_wr_data", int'(wr_data), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_timing_err", int'(timing_err), 0);
    rst = 1'b0;

    // ideal stream at half rate, then a short line while locked
    rand_gaps = 0;
    repeat (3) frame(VT, -1, -1);
    frame(VT, 5, -1);
    repeat (2) frame(VT, -1, -1);

    // frame-length errors, in MEASURE and while locked
    apply_reset();
    frame(VT - 1, -1, -1);
    frame(VT, -1, -1);
    frame(VT, -1, -1);
    frame(VT - 1, -1, -1);
    frame(VT, -1, -1);
    frame(VT, -1, -1);

    // reset in the middle of a locked frame
    apply_reset();
    repeat (3) frame(VT, -1, -1);
    frame(VT, -1, 10);
    repeat (2) frame(VT, -1, -1);

    // random pix_en gaps
    apply_reset();
    rand_gaps = 1;
    repeat (3) frame(VT, -1, -1);

    @(negedge clk);
    pix_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("writes_outstanding", wq.size(), 0);
    chk("timing_err_outstanding", eq.size(), 0);
    chk("locked_outstanding", lq.size(), 0);
    chk("total_writes", n_seen, n_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
